midi_poly_tracker: RTL and testbench
====================================

Name: midi_poly_tracker

Overview:
- Polyphonic, parametrised successor to the single-note MIDI processor.
- Consumes the byte stream from the MIDI byte reader and parses channel messages with running status and a channel filter.
- Tracks up to NUM_VOICES held notes, using a voice-allocation table with round-robin stealing.
- Queues decoded events in a show-ahead FIFO for the bus-side register file; raises a level interrupt while events are pending.

Parameters:
- NUM_VOICES, 4: number of voice slots, 1..8.
- FIFO_DEPTH, 8: event FIFO entries; power of 2, at least 2.
- FIFO_AW, 3: log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- byte_valid  in  1  one-cycle pulse; byte_data is valid this cycle.
- byte_data  in  8  received MIDI byte.
- chan_sel  in  4  channel accepted when omni=0.
- omni  in  1  1 = accept all channels.
- int_en  in  1  interrupt enable.
- evt_pop  in  1  pop FIFO head.
- ovf_clr  in  1  clear overflow flag.
- evt_valid  out  1  FIFO not empty.
- evt_data  out  24  FIFO head: [23:22] type (0 note-on, 1 note-off, 2 CC, 3 pitch bend), [21:18] channel, [17:11] d0, [10:4] d1, [3] voice-valid, [2:0] voice index.
- fifo_count  out  FIFO_AW+1  occupancy.
- overflow  out  1  sticky; an event was dropped.
- voice_active  out  NUM_VOICES  per-slot held flag.
- voice_notes  out  7*NUM_VOICES  slot k note at [7k+6:7k].
- modulation  out  7  last CC1 value.
- pitch_bend  out  14  last pitch-bend value, {msb,lsb}.
- int_sig  out  1  int_en & evt_valid (combinational from registers).

Behaviour:
- Reset (rst=1 at clk edge): parser to IDLE, running status cleared, voices inactive, notes 0, steal_ptr 0, FIFO empty, overflow 0, modulation 0, pitch_bend 14'h2000. A message in progress is discarded.
- Parser states:
  - IDLE: no running status.
  - WAIT_D0: status held, expecting first data byte.
  - WAIT_D1: expecting second data byte.
- Parser transitions and byte classes:
  - 0x80–0xEF (channel status): latch status and channel, go to WAIT_D0.
  - 0xF0–0xF7 (system common): go to IDLE, clear running status.
  - 0xF8–0xFF (realtime): ignored; state and captured data unchanged.
  - Data byte in IDLE: ignored (this also discards SysEx payload).
  - Data byte in WAIT_D0 for 0xC/0xD: message complete, discarded, stay in WAIT_D0 (running status).
  - Data byte in WAIT_D0 for other statuses: capture d0, go to WAIT_D1.
  - Data byte in WAIT_D1: message complete, go to WAIT_D0 (running status).
- Accept rule: a complete message is accepted only if omni=1 or channel==chan_sel. Status 0xA is always discarded.
- Latency: effects of an accepted message (voice table, outputs, FIFO push) are visible on the clk edge after the cycle in which its final byte_valid arrives.
- Note-on, velocity>0:
  - Note already held in slot k: retrigger. Event uses voice k; table unchanged.
  - Otherwise: allocate the lowest-index free slot.
  - All slots full: steal slot steal_ptr, then steal_ptr <= (steal_ptr+1) mod NUM_VOICES. steal_ptr changes only on a steal.
  - Event carries voice-valid=1.
- Note-off (0x8, or 0x9 with velocity 0):
  - Note held in slot k: clear slot k, push note-off with voice k, d1 = velocity.
  - Note not held: no event, no change.
- Control change (0xB):
  - Every accepted CC pushes a CC event with voice-valid=0.
  - d0=1: modulation <= d1.
  - d0=123: all slots inactive.
- Pitch bend (0xE): pitch_bend <= {d1,d0}; push event with voice-valid=0.
- FIFO behaviour:
  - Show-ahead: evt_data is valid while evt_valid=1.
  - Pop when evt_valid=0: ignored.
  - Push and pop in the same cycle: both occur, count unchanged, including when the FIFO is full.
  - Push while full with no pop: event dropped, overflow <= 1. The voice table is still updated.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow flag: ovf_clr clears it. If ovf_clr and a new overflow occur in the same cycle, the overflow wins (flag stays 1).
- Unused voice_notes bits of inactive slots keep their last value.

Test Plan:
- Reset, then bytes 0x90,0x3C,0x64 on channel 0, omni=1 -> voice_active=0001, slot0 note 0x3C, one event 24'h0 type0 d0=0x3C d1=0x64 voice 0 valid, int_sig=1 when int_en=1.
- Running status: 0x90,0x3C,0x40,0x3E,0x40,0x3C,0x00 -> slots 0/1 get 0x3C/0x3E, then slot0 cleared with note-off voice 0; 3 events queued; 0xF8 injected between data bytes leaves the result identical.
- NUM_VOICES=4: note-ons 60,61,62,63,64 -> 64 steals slot0 (steal_ptr 0->1); note-on 65 steals slot1; note-off 99 produces no event.
- chan_sel=2, omni=0: 0x91,0x40,0x7F ignored; 0x92,0x40,0x7F accepted; 0xB2,0x01,0x55 -> modulation=0x55; 0xE2,0x00,0x40 -> pitch_bend=0x2000; 0xB2,0x7B,0x00 clears all voices.
- FIFO_DEPTH=8: 9 events with no pop -> fifo_count=8, overflow=1, first event still at head; push+pop in the same cycle while full keeps count 8; ovf_clr -> overflow=0.
- Reset asserted after 0x90,0x3C -> following 0x64 ignored (IDLE); outputs at reset values.

Source files
------------

// File: rtl/midi_poly_tracker.sv
// midi_poly_tracker: polyphonic MIDI channel-message parser with a voice
// allocation table (round-robin stealing) and a show-ahead event FIFO that
// feeds the bus-side register file. int_sig is raised while events are pending.
module midi_poly_tracker #(
    parameter int NUM_VOICES = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      byte_valid,
    input  logic [7:0]                byte_data,
    input  logic [3:0]                chan_sel,
    input  logic                      omni,
    input  logic                      int_en,
    input  logic                      evt_pop,
    input  logic                      ovf_clr,
    output logic                      evt_valid,
    output logic [23:0]               evt_data,
    output logic [FIFO_AW:0]          fifo_count,
    output logic                      overflow,
    output logic [NUM_VOICES-1:0]     voice_active,
    output logic [7*NUM_VOICES-1:0]   voice_notes,
    output logic [6:0]                modulation,
    output logic [13:0]               pitch_bend,
    output logic                      int_sig
);

    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D0 = 2'd1,
        ST_WAIT_D1 = 2'd2
    } pstate_t;

    // Event type codes carried in evt_data[23:22]
    localparam logic [1:0] EVT_NOTE_ON  = 2'd0;
    localparam logic [1:0] EVT_NOTE_OFF = 2'd1;
    localparam logic [1:0] EVT_CC       = 2'd2;
    localparam logic [1:0] EVT_BEND     = 2'd3;

    // Pack the FIFO event word
    function automatic logic [23:0] pack_evt(
        input logic [1:0] typ,
        input logic [3:0] ch,
        input logic [6:0] d0,
        input logic [6:0] d1,
        input logic       vv,
        input logic [2:0] vi
    );
        return {typ, ch, d0, d1, vv, vi};
    endfunction

    // Index of the lowest set bit (0 when none is set)
    function automatic logic [VW-1:0] lowest_set(input logic [NUM_VOICES-1:0] v);
        logic [VW-1:0] idx;
        idx = '0;
        for (int k = NUM_VOICES - 1; k >= 0; k--) begin
            if (v[k]) begin
                idx = VW'(k);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Parser state
    pstate_t     state_r;
    logic [3:0]  status_r;
    logic [3:0]  chan_r;
    logic [6:0]  d0_r;

    // Voice table and controller state
    logic [NUM_VOICES-1:0]       active_r;
    logic [NUM_VOICES-1:0][6:0]  notes_r;
    logic [VW-1:0]               steal_ptr_r;
    logic [6:0]                  mod_r;
    logic [13:0]                 bend_r;

    // FIFO state
    logic [23:0]        mem_r [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [FIFO_AW:0]   count_r;
    logic               ovf_r;

    // Byte classification and message completion
    logic byte_realtime_s;
    logic byte_syscom_s;
    logic one_byte_msg_s;
    logic exec_s;
    logic [6:0] d1_s;

    assign byte_realtime_s = (byte_data[7:3] == 5'b11111);
    assign byte_syscom_s   = (byte_data[7:3] == 5'b11110);
    assign one_byte_msg_s  = (status_r == 4'hC) || (status_r == 4'hD);
    assign d1_s            = byte_data[6:0];
    // A two-data-byte message completes on a data byte in WAIT_D1; program
    // change / aftertouch complete in WAIT_D0 but have no effect, so only the
    // WAIT_D1 case can ever be executed.
    assign exec_s = byte_valid && !byte_data[7] && (state_r == ST_WAIT_D1) &&
                    (omni || (chan_r == chan_sel)) && (status_r != 4'hA);

    // Voice lookup
    logic [NUM_VOICES-1:0] match_vec_s;
    logic [NUM_VOICES-1:0] free_vec_s;
    logic                  hit_s;
    logic                  free_s;
    logic [VW-1:0]         hit_idx_s;
    logic [VW-1:0]         free_idx_s;

    // Per-slot match and free flags for the note carried in d0
    always_comb begin
        match_vec_s = '0;
        free_vec_s  = '0;
        for (int k = 0; k < NUM_VOICES; k++) begin
            match_vec_s[k] = active_r[k] && (notes_r[k] == d0_r);
            free_vec_s[k]  = !active_r[k];
        end
    end

    assign hit_s      = |match_vec_s;
    assign free_s     = |free_vec_s;
    assign hit_idx_s  = lowest_set(match_vec_s);
    assign free_idx_s = lowest_set(free_vec_s);

    // Next-state values for the voice table, controllers and the pushed event
    logic [NUM_VOICES-1:0]       active_n_s;
    logic [NUM_VOICES-1:0][6:0]  notes_n_s;
    logic [VW-1:0]               steal_n_s;
    logic [6:0]                  mod_n_s;
    logic [13:0]                 bend_n_s;
    logic                        push_s;
    logic [23:0]                 evt_s;
    logic                        note_on_s;
    logic                        note_off_s;

    assign note_on_s  = (status_r == 4'h9) && (d1_s != 7'd0);
    assign note_off_s = (status_r == 4'h8) || ((status_r == 4'h9) && (d1_s == 7'd0));

    // Execute an accepted message against the voice table
    always_comb begin
        active_n_s = active_r;
        notes_n_s  = notes_r;
        steal_n_s  = steal_ptr_r;
        mod_n_s    = mod_r;
        bend_n_s   = bend_r;
        push_s     = 1'b0;
        evt_s      = 24'd0;
        if (exec_s) begin
            case (status_r)
                4'h8, 4'h9: begin
                    if (note_on_s) begin
                        push_s = 1'b1;
                        if (hit_s) begin
                            evt_s = pack_evt(EVT_NOTE_ON, chan_r, d0_r, d1_s, 1'b1, 3'(hit_idx_s));
                        end else if (free_s) begin
                            active_n_s[free_idx_s] = 1'b1;
                            notes_n_s[free_idx_s]  = d0_r;
                            evt_s = pack_evt(EVT_NOTE_ON, chan_r, d0_r, d1_s, 1'b1, 3'(free_idx_s));
                        end else begin
                            notes_n_s[steal_ptr_r] = d0_r;
                            evt_s = pack_evt(EVT_NOTE_ON, chan_r, d0_r, d1_s, 1'b1, 3'(steal_ptr_r));
                            steal_n_s = (steal_ptr_r == VW'(NUM_VOICES - 1)) ? '0 : steal_ptr_r + VW'(1);
                        end
                    end else if (note_off_s && hit_s) begin
                        push_s = 1'b1;
                        active_n_s[hit_idx_s] = 1'b0;
                        evt_s = pack_evt(EVT_NOTE_OFF, chan_r, d0_r, d1_s, 1'b1, 3'(hit_idx_s));
                    end else begin
                        push_s = 1'b0;
                    end
                end
                4'hB: begin
                    push_s = 1'b1;
                    evt_s  = pack_evt(EVT_CC, chan_r, d0_r, d1_s, 1'b0, 3'd0);
                    if (d0_r == 7'd1) begin
                        mod_n_s = d1_s;
                    end else if (d0_r == 7'd123) begin
                        active_n_s = '0;
                    end else begin
                        mod_n_s = mod_r;
                    end
                end
                4'hE: begin
                    push_s   = 1'b1;
                    bend_n_s = {d1_s, d0_r};
                    evt_s    = pack_evt(EVT_BEND, chan_r, d0_r, d1_s, 1'b0, 3'd0);
                end
                default: begin
                    push_s = 1'b0;
                end
            endcase
        end else begin
            push_s = 1'b0;
        end
    end

    // FIFO control
    logic full_s;
    logic pop_s;
    logic push_ok_s;
    logic ovf_set_s;

    assign full_s    = (count_r == (FIFO_AW + 1)'(FIFO_DEPTH));
    assign pop_s     = evt_pop && (count_r != '0);
    assign push_ok_s = push_s && (!full_s || pop_s);
    assign ovf_set_s = push_s && full_s && !pop_s;

    // Message parser FSM with running status
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            status_r <= 4'h0;
            chan_r   <= 4'h0;
            d0_r     <= 7'd0;
        end else if (byte_valid) begin
            if (byte_realtime_s) begin
                state_r <= state_r;
            end else if (byte_syscom_s) begin
                state_r  <= ST_IDLE;
                status_r <= 4'h0;
            end else if (byte_data[7]) begin
                status_r <= byte_data[7:4];
                chan_r   <= byte_data[3:0];
                state_r  <= ST_WAIT_D0;
            end else begin
                case (state_r)
                    ST_IDLE: state_r <= ST_IDLE;
                    ST_WAIT_D0: begin
                        if (!one_byte_msg_s) begin
                            d0_r    <= byte_data[6:0];
                            state_r <= ST_WAIT_D1;
                        end
                    end
                    ST_WAIT_D1: state_r <= ST_WAIT_D0;
                    default:    state_r <= ST_IDLE;
                endcase
            end
        end
    end

    // Voice table, steal pointer and controller registers
    always_ff @(posedge clk) begin
        if (rst) begin
            active_r    <= '0;
            notes_r     <= '0;
            steal_ptr_r <= '0;
            mod_r       <= 7'd0;
            bend_r      <= 14'h2000;
        end else begin
            active_r    <= active_n_s;
            notes_r     <= notes_n_s;
            steal_ptr_r <= steal_n_s;
            mod_r       <= mod_n_s;
            bend_r      <= bend_n_s;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            ovf_r    <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + (FIFO_AW + 1)'(1);
                2'b01:   count_r <= count_r - (FIFO_AW + 1)'(1);
                default: count_r <= count_r;
            endcase
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // FIFO storage (contents need no reset; validity is tracked by count_r)
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= evt_s;
        end
    end

    assign evt_valid    = (count_r != '0);
    assign evt_data     = mem_r[rd_ptr_r];
    assign fifo_count   = count_r;
    assign overflow     = ovf_r;
    assign voice_active = active_r;
    assign voice_notes  = notes_r;
    assign modulation   = mod_r;
    assign pitch_bend   = bend_r;
    assign int_sig      = int_en && (count_r != '0);

endmodule

// File: tb/tb_midi_poly_tracker.sv
// Self-checking bench for midi_poly_tracker: expected events are queued as
// stimulus is driven and compared as the FIFO is drained.
module tb_midi_poly_tracker;

    localparam int NV  = 4;
    localparam int FD  = 8;
    localparam int FAW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            byte_valid;
    logic [7:0]      byte_data;
    logic [3:0]      chan_sel;
    logic            omni;
    logic            int_en;
    logic            evt_pop;
    logic            ovf_clr;
    logic            evt_valid;
    logic [23:0]     evt_data;
    logic [FAW:0]    fifo_count;
    logic            overflow;
    logic [NV-1:0]   voice_active;
    logic [7*NV-1:0] voice_notes;
    logic [6:0]      modulation;
    logic [13:0]     pitch_bend;
    logic            int_sig;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    midi_poly_tracker #(.NUM_VOICES(NV), .FIFO_DEPTH(FD), .FIFO_AW(FAW)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .chan_sel(chan_sel), .omni(omni), .int_en(int_en), .evt_pop(evt_pop),
        .ovf_clr(ovf_clr), .evt_valid(evt_valid), .evt_data(evt_data),
        .fifo_count(fifo_count), .overflow(overflow), .voice_active(voice_active),
        .voice_notes(voice_notes), .modulation(modulation), .pitch_bend(pitch_bend),
        .int_sig(int_sig)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [23:0] mk(input int t, input int ch, input int d0,
                                       input int d1, input int vv, input int vi);
        logic [23:0] w;
        w = {t[1:0], ch[3:0], d0[6:0], d1[6:0], vv[0], vi[2:0]};
        return w;
    endfunction

    function automatic logic [6:0] note_of(input int k);
        return voice_notes[7*k +: 7];
    endfunction

    // One cycle of stimulus, applied at a falling edge and removed at the next
    task automatic drive(input logic bv, input logic [7:0] b, input logic pop, input logic clr);
        @(negedge clk);
        byte_valid = bv; byte_data = b; evt_pop = pop; ovf_clr = clr;
        @(negedge clk);
        byte_valid = 1'b0; byte_data = 8'h00; evt_pop = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send(a); send(b); send(c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Pop every expected event, checking the head before each pop
    task automatic drain(input string tag);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, evt_valid, 32'd1);
            chk({tag, "_evt"}, evt_data, exp_q.pop_front());
            drive(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk({tag, "_empty"}, evt_valid, 32'd0);
    endtask

    initial begin
        rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; chan_sel = 4'd0;
        omni = 1'b1; int_en = 1'b1; evt_pop = 1'b0; ovf_clr = 1'b0;

        // Reset state
        do_reset();
        chk("rst_valid", evt_valid, 32'd0);
        chk("rst_count", fifo_count, 32'd0);
        chk("rst_ovf", overflow, 32'd0);
        chk("rst_active", voice_active, 32'd0);
        chk("rst_mod", modulation, 32'd0);
        chk("rst_bend", pitch_bend, 32'h2000);
        chk("rst_int", int_sig, 32'd0);

        // Single note-on
        send3(8'h90, 8'h3C, 8'h64);
        exp_q.push_back(mk(0, 0, 8'h3C, 8'h64, 1, 0));
        chk("t1_active", voice_active, 32'h1);
        chk("t1_note0", note_of(0), 32'h3C);
        chk("t1_count", fifo_count, 32'd1);
        chk("t1_int", int_sig, 32'd1);
        int_en = 1'b0;
        @(negedge clk);
        chk("t1_int_dis", int_sig, 32'd0);
        int_en = 1'b1;
        drain("t1");
        chk("t1_int_off", int_sig, 32'd0);

        // Running status with realtime bytes injected between data bytes
        do_reset();
        send3(8'h90, 8'h3C, 8'h40);
        send3(8'h3E, 8'hF8, 8'h40);
        send3(8'h3C, 8'hF8, 8'h00);
        exp_q.push_back(mk(0, 0, 8'h3C, 8'h40, 1, 0));
        exp_q.push_back(mk(0, 0, 8'h3E, 8'h40, 1, 1));
        exp_q.push_back(mk(1, 0, 8'h3C, 8'h00, 1, 0));
        chk("t2_active", voice_active, 32'h2);
        chk("t2_note1", note_of(1), 32'h3E);
        chk("t2_note0_kept", note_of(0), 32'h3C);
        chk("t2_count", fifo_count, 32'd3);
        drain("t2");

        // Allocation, round-robin stealing, retrigger, unmatched note-off
        do_reset();
        send(8'h90);
        for (int n = 8'h3C; n <= 8'h41; n++) begin
            send(8'(n)); send(8'h40);
        end
        exp_q.push_back(mk(0, 0, 8'h3C, 8'h40, 1, 0));
        exp_q.push_back(mk(0, 0, 8'h3D, 8'h40, 1, 1));
        exp_q.push_back(mk(0, 0, 8'h3E, 8'h40, 1, 2));
        exp_q.push_back(mk(0, 0, 8'h3F, 8'h40, 1, 3));
        exp_q.push_back(mk(0, 0, 8'h40, 8'h40, 1, 0));
        exp_q.push_back(mk(0, 0, 8'h41, 8'h40, 1, 1));
        send(8'h63); send(8'h00);
        chk("t3_noff_none", fifo_count, 32'd6);
        send(8'h3E); send(8'h50);
        exp_q.push_back(mk(0, 0, 8'h3E, 8'h50, 1, 2));
        chk("t3_active", voice_active, 32'hF);
        chk("t3_note0", note_of(0), 32'h40);
        chk("t3_note1", note_of(1), 32'h41);
        chk("t3_note2", note_of(2), 32'h3E);
        chk("t3_note3", note_of(3), 32'h3F);
        send(8'h42); send(8'h40);
        exp_q.push_back(mk(0, 0, 8'h42, 8'h40, 1, 2));
        chk("t3_note2_steal", note_of(2), 32'h42);
        chk("t3_count", fifo_count, 32'd8);
        chk("t3_ovf", overflow, 32'd0);
        drain("t3");

        // Channel filter, CC, pitch bend, discarded message types
        do_reset();
        omni = 1'b0; chan_sel = 4'd2;
        send3(8'h91, 8'h40, 8'h7F);
        chk("t4_filtered", fifo_count, 32'd0);
        chk("t4_filt_active", voice_active, 32'd0);
        send3(8'h92, 8'h40, 8'h7F);
        exp_q.push_back(mk(0, 2, 8'h40, 8'h7F, 1, 0));
        chk("t4_active", voice_active, 32'h1);
        send3(8'hC2, 8'h05, 8'h06);
        send3(8'hA2, 8'h40, 8'h40);
        chk("t4_discard", fifo_count, 32'd1);
        send3(8'hB2, 8'h01, 8'h55);
        exp_q.push_back(mk(2, 2, 1, 8'h55, 0, 0));
        chk("t4_mod", modulation, 32'h55);
        send3(8'hE2, 8'h00, 8'h40);
        exp_q.push_back(mk(3, 2, 0, 8'h40, 0, 0));
        chk("t4_bend", pitch_bend, 32'h2000);
        send3(8'hB2, 8'h7B, 8'h00);
        exp_q.push_back(mk(2, 2, 8'h7B, 0, 0, 0));
        chk("t4_allnotesoff", voice_active, 32'd0);
        chk("t4_count", fifo_count, 32'd4);
        drain("t4");
        omni = 1'b1; chan_sel = 4'd0;

        // FIFO full, overflow, simultaneous push/pop, overflow clear priority
        do_reset();
        send(8'hE0);
        for (int i = 0; i < 9; i++) begin
            send(8'(i)); send(8'h10);
            if (i < 8) exp_q.push_back(mk(3, 0, i, 8'h10, 0, 0));
        end
        chk("t5_count", fifo_count, 32'd8);
        chk("t5_ovf", overflow, 32'd1);
        chk("t5_head", evt_data, exp_q[0]);
        chk("t5_bend", pitch_bend, 32'h0808);
        send(8'h09);
        drive(1'b1, 8'h10, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        exp_q.push_back(mk(3, 0, 9, 8'h10, 0, 0));
        chk("t5_pp_count", fifo_count, 32'd8);
        chk("t5_pp_head", evt_data, exp_q[0]);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t5_ovf_clr", overflow, 32'd0);
        send(8'h0A);
        drive(1'b1, 8'h10, 1'b0, 1'b1);
        chk("t5_ovf_wins", overflow, 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t5_ovf_clr2", overflow, 32'd0);
        drain("t5");

        // Reset in mid-message discards it; empty pop and system common
        do_reset();
        send3(8'hB0, 8'h01, 8'h22);
        chk("t6_mod", modulation, 32'h22);
        send(8'h90); send(8'h3C);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(8'h64);
        chk("t6_active", voice_active, 32'd0);
        chk("t6_count", fifo_count, 32'd0);
        chk("t6_mod_rst", modulation, 32'd0);
        chk("t6_bend", pitch_bend, 32'h2000);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t6_empty_pop", fifo_count, 32'd0);
        send(8'h90); send(8'hF0); send(8'h3C); send(8'h64);
        chk("t6_syscom", fifo_count, 32'd0);
        chk("t6_syscom_act", voice_active, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
